// File: rtl/gb_timer_if.sv
// Register port of the Game Boy timer: FF04-FF07 access plus the IRQ line.
// The CPU side uses the master modport and the timer uses the slave modport.
interface gb_timer_if;
  logic [1:0] reg_addr;
  logic       reg_wr;
  logic [7:0] reg_wdata;
  logic [7:0] reg_rdata;
  logic       timer_irq;

  modport master (
    output reg_addr, reg_wr, reg_wdata,
    input  reg_rdata, timer_irq
  );

  modport slave (
    input  reg_addr, reg_wr, reg_wdata,
    output reg_rdata, timer_irq
  );
endinterface

// File: rtl/gb_timer.sv
// Game Boy DIV/TIMA/TMA/TAC timer with a one-cycle overflow IRQ.
// GB_TIMER_RELOAD_DELAY_EN adds the delayed TMA reload (DELAY_TICKS T-cycles).
module gb_timer #(
  parameter int SYS_CNT_W = 16
`ifdef GB_TIMER_RELOAD_DELAY_EN
  , parameter int DELAY_TICKS = 4
`endif
) (
  input  logic        clock_in,
  input  logic        reset_b,
  input  logic        tick_en,
  gb_timer_if.slave   bus
);

  logic [SYS_CNT_W-1:0] sys_cnt_q, sys_cnt_d;
  logic [7:0]           tima_q, tima_d;
  logic [7:0]           tma_q, tma_d;
  logic [2:0]           tac_q, tac_d;
  logic                 sel_q, sel_d;
  logic                 irq_q, irq_d;
  logic                 wr_div, wr_tima;
  logic                 wr_tma, wr_tac;
  logic                 inc;

`ifdef GB_TIMER_RELOAD_DELAY_EN
  localparam int PCW = $clog2(DELAY_TICKS + 1);
  logic           pend_q, pend_d;
  logic [PCW-1:0] pcnt_q, pcnt_d;
`endif

  function automatic logic sel_bit(
    input logic [1:0]           m,
    input logic [SYS_CNT_W-1:0] c
  );
    logic b;
    case (m)
      2'b00:   b = c[9];
      2'b01:   b = c[3];
      2'b10:   b = c[5];
      default: b = c[7];
    endcase
    return b;
  endfunction

  always_comb begin
    wr_div  = bus.reg_wr & (bus.reg_addr == 2'd0);
    wr_tima = bus.reg_wr & (bus.reg_addr == 2'd1);
    wr_tma  = bus.reg_wr & (bus.reg_addr == 2'd2);
    wr_tac  = bus.reg_wr & (bus.reg_addr == 2'd3);

    sys_cnt_d = sys_cnt_q;
    if (wr_div)
      sys_cnt_d = '0;
    else if (tick_en)
      sys_cnt_d = sys_cnt_q + 1'b1;

    tma_d = wr_tma ? bus.reg_wdata : tma_q;
    tac_d = wr_tac ? bus.reg_wdata[2:0] : tac_q;

    // Edge detect on post-update state so DIV/TAC writes glitch TIMA
    sel_d = tac_d[2] & sel_bit(tac_d[1:0], sys_cnt_d);
    inc   = sel_q & ~sel_d;

    tima_d = tima_q;
    irq_d  = 1'b0;
`ifdef GB_TIMER_RELOAD_DELAY_EN
    pend_d = pend_q;
    pcnt_d = pcnt_q;
    if (wr_tima) begin
      tima_d = bus.reg_wdata;
      pend_d = 1'b0;
      pcnt_d = '0;
    end else if (pend_q) begin
      if (tick_en) begin
        if (pcnt_q == PCW'(DELAY_TICKS - 1)) begin
          tima_d = tma_d;
          irq_d  = 1'b1;
          pend_d = 1'b0;
          pcnt_d = '0;
        end else begin
          pcnt_d = pcnt_q + 1'b1;
        end
      end
    end else if (inc) begin
      if (tima_q == 8'hFF) begin
        tima_d = 8'h00;
        pend_d = 1'b1;
        pcnt_d = '0;
      end else begin
        tima_d = tima_q + 8'd1;
      end
    end
`else
    if (wr_tima) begin
      tima_d = bus.reg_wdata;
    end else if (inc) begin
      if (tima_q == 8'hFF) begin
        tima_d = tma_d;
        irq_d  = 1'b1;
      end else begin
        tima_d = tima_q + 8'd1;
      end
    end
`endif
  end

  always_ff @(posedge clock_in) begin
    if (!reset_b) begin
      sys_cnt_q <= '0;
      tima_q    <= '0;
      tma_q     <= '0;
      tac_q     <= '0;
      sel_q     <= 1'b0;
      irq_q     <= 1'b0;
    end else begin
      sys_cnt_q <= sys_cnt_d;
      tima_q    <= tima_d;
      tma_q     <= tma_d;
      tac_q     <= tac_d;
      sel_q     <= sel_d;
      irq_q     <= irq_d;
    end
  end

`ifdef GB_TIMER_RELOAD_DELAY_EN
  always_ff @(posedge clock_in) begin
    if (!reset_b) begin
      pend_q <= 1'b0;
      pcnt_q <= '0;
    end else begin
      pend_q <= pend_d;
      pcnt_q <= pcnt_d;
    end
  end
`endif

  always_comb begin
    bus.reg_rdata = 8'h00;
    case (bus.reg_addr)
      2'd0:    bus.reg_rdata = sys_cnt_q[SYS_CNT_W-1 -: 8];
      2'd1:    bus.reg_rdata = tima_q;
      2'd2:    bus.reg_rdata = tma_q;
      default: bus.reg_rdata = {5'b11111, tac_q};
    endcase
  end

  assign bus.timer_irq = irq_q;

endmodule

// File: tb/tb_gb_timer.sv
// Directed bench for gb_timer: DIV, TIMA ticking, overflow reload, glitches.
// Expectations follow GB_TIMER_RELOAD_DELAY_EN when it is defined.
module tb_gb_timer;
  logic clk = 1'b0;
  logic rst_b = 1'b0;
  logic tick_en = 1'b0;
  int   n_vec = 0;
  int   n_bad = 0;
  int   irq_cnt = 0;
  int   i0;
  logic [7:0] v;

  gb_timer_if bus ();

  gb_timer dut (
    .clock_in (clk),
    .reset_b  (rst_b),
    .tick_en  (tick_en),
    .bus      (bus.slave)
  );

  always #5 clk = ~clk;

  always @(posedge clk)
    if (bus.timer_irq === 1'b1) irq_cnt++;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    tick_en = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic ticks(input int n);
    tick_en = 1'b1;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
    tick_en = 1'b0;
  endtask

  task automatic wr(input logic [1:0] a, input logic [7:0] d);
    bus.reg_addr  = a;
    bus.reg_wdata = d;
    bus.reg_wr    = 1'b1;
    tick_en       = 1'b0;
    @(posedge clk);
    #1;
    bus.reg_wr = 1'b0;
  endtask

  task automatic rd(input logic [1:0] a, output logic [7:0] d);
    bus.reg_addr = a;
    #1;
    d = bus.reg_rdata;
  endtask

  initial begin
    bus.reg_addr  = 2'd0;
    bus.reg_wr    = 1'b0;
    bus.reg_wdata = 8'h00;
    idle(2);
    rst_b = 1'b1;

    // 1: reset state and DIV
    rd(0, v); chk("rst_div", v, 8'h00);
    rd(1, v); chk("rst_tima", v, 8'h00);
    rd(2, v); chk("rst_tma", v, 8'h00);
    rd(3, v); chk("rst_tac", v, 8'hF8);
    chk("rst_irq", bus.timer_irq, 1'b0);
    ticks(256);
    rd(0, v); chk("div_256", v, 8'h01);
    ticks(65536 - 256);
    rd(0, v); chk("div_wrap", v, 8'h00);

    // 2: TAC=05 ticking and one overflow in 4096 ticks
    wr(3, 8'h05);
    wr(1, 8'h00);
    i0 = irq_cnt;
    ticks(16);
    rd(1, v); chk("tima_16", v, 8'h01);
    ticks(16 * 255);
    ticks(4);
    idle(1);
    rd(1, v); chk("tima_wrap", v, 8'h00);
    chk("irq_once", irq_cnt - i0, 1);

    // 3: reload from TMA
    wr(2, 8'hF0);
    wr(0, 8'h00);
    wr(1, 8'hFF);
    i0 = irq_cnt;
    ticks(16);
`ifdef GB_TIMER_RELOAD_DELAY_EN
    rd(1, v); chk("ovf_zero", v, 8'h00);
    ticks(3);
    rd(1, v); chk("pend_zero", v, 8'h00);
    chk("pend_noirq", irq_cnt - i0 + int'(bus.timer_irq), 0);
    ticks(1);
`endif
    rd(1, v); chk("reload_f0", v, 8'hF0);
    chk("irq_high", bus.timer_irq, 1'b1);
    idle(1);
    chk("irq_low", bus.timer_irq, 1'b0);
    chk("irq_one", irq_cnt - i0, 1);

    // 4: DIV write while selected bit high glitches TIMA
    wr(0, 8'h00);
    wr(1, 8'h10);
    ticks(8);
    rd(1, v); chk("tima_pre", v, 8'h10);
    wr(0, 8'h5A);
    rd(0, v); chk("div_clr", v, 8'h00);
    rd(1, v); chk("div_glitch", v, 8'h11);

`ifdef GB_TIMER_RELOAD_DELAY_EN
    // 5: TIMA write during pending cancels reload
    wr(0, 8'h00);
    wr(1, 8'hFF);
    i0 = irq_cnt;
    ticks(16);
    ticks(2);
    wr(1, 8'h42);
    ticks(4);
    idle(1);
    rd(1, v); chk("cancel_tima", v, 8'h42);
    chk("cancel_irq", irq_cnt - i0, 0);
`else
    // 6a: TMA write in the overflow cycle
    wr(0, 8'h00);
    wr(1, 8'hFF);
    i0 = irq_cnt;
    ticks(15);
    bus.reg_addr  = 2'd2;
    bus.reg_wdata = 8'h80;
    bus.reg_wr    = 1'b1;
    tick_en       = 1'b1;
    @(posedge clk);
    #1;
    bus.reg_wr = 1'b0;
    tick_en    = 1'b0;
    rd(1, v); chk("same_tma", v, 8'h80);
    idle(1);
    chk("same_irq", irq_cnt - i0, 1);
`endif

    // 6b: reset on the overflowing tick
    wr(0, 8'h00);
    wr(1, 8'hFF);
    i0 = irq_cnt;
    ticks(15);
    rst_b   = 1'b0;
    tick_en = 1'b1;
    @(posedge clk);
    #1;
    tick_en = 1'b0;
    rst_b   = 1'b1;
    idle(6);
    rd(0, v); chk("mrst_div", v, 8'h00);
    rd(1, v); chk("mrst_tima", v, 8'h00);
    rd(2, v); chk("mrst_tma", v, 8'h00);
    rd(3, v); chk("mrst_tac", v, 8'hF8);
    chk("mrst_irq", irq_cnt - i0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
